cmd_issuer: RTL

CMD_ISSUER -- requirements
Module: cmd_issuer

---
 rtl/cmd_issuer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cmd_issuer.sv
// DRAM command issuer: pops encoded commands from a first-word-fall-through FIFO,
// drives the DRAM command pins for one cycle, then holds off for the command's gap.
module cmd_issuer #(
    parameter int unsigned ADDR_BITS = 14,
    parameter int unsigned T_ACT_GAP = 4,
    parameter int unsigned T_RD_GAP  = 2,
    parameter int unsigned T_WR_GAP  = 6,
    parameter int unsigned T_PRE_GAP = 4,
    parameter int unsigned T_REF_GAP = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 isu_fifo_empty,
    input  logic [ADDR_BITS+5:0] isu_fifo_out,
    output logic                 isu_fifo_rd,
    output logic                 dram_cs_n,
    output logic                 dram_ras_n,
    output logic                 dram_cas_n,
    output logic                 dram_we_n,
    output logic [ADDR_BITS-1:0] dram_addr,
    output logic [2:0]           dram_ba,
    output logic                 rd_issue,
    output logic                 wr_issue,
    output logic                 busy,
    output logic                 cmd_err
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    logic [1:0]           state;
    logic [7:0]           cnt;
    logic [2:0]           cmd_r;
    logic [ADDR_BITS-1:0] addr_r;
    logic [2:0]           bank_r;
    logic [7:0]           gap_load;
    logic                 legal_op;

    // Counter holds gap-2: one cycle is the ISSUE itself, one is the pop cycle at count zero.
    always_comb begin
        gap_load = 8'd0;
        legal_op = 1'b1;
        case (cmd_r)
            CMD_ACT: gap_load = 8'(T_ACT_GAP - 2);
            CMD_RD:  gap_load = 8'(T_RD_GAP - 2);
            CMD_WR:  gap_load = 8'(T_WR_GAP - 2);
            CMD_PRE: gap_load = 8'(T_PRE_GAP - 2);
            CMD_REF: gap_load = 8'(T_REF_GAP - 2);
            default: legal_op = 1'b0;
        endcase
    end

    // Gated by rst_n so the strobe is low throughout reset even though IDLE may see data.
    assign isu_fifo_rd = rst_n && !isu_fifo_empty &&
                         ((state == S_IDLE) || ((state == S_WAIT) && (cnt == 8'd0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 8'd0;
            cmd_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (isu_fifo_rd) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (legal_op) begin
                        cnt   <= gap_load;
                        state <= S_WAIT;
                    end else begin
                        state <= S_IDLE;
                        if (cmd_r > CMD_REF) cmd_err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt != 8'd0)     cnt   <= cnt - 8'd1;
                    else if (isu_fifo_rd) state <= S_ISSUE;
                    else                  state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r  <= CMD_NOP;
            addr_r <= '0;
            bank_r <= 3'd0;
        end else if (isu_fifo_rd) begin
            cmd_r  <= isu_fifo_out[ADDR_BITS+5:ADDR_BITS+3];
            addr_r <= isu_fifo_out[ADDR_BITS+2:3];
            bank_r <= isu_fifo_out[2:0];
        end
    end

    always_comb begin
        {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = 4'b1111;
        dram_addr = '0;
        dram_ba   = 3'd0;
        rd_issue  = 1'b0;
        wr_issue  = 1'b0;
        if (state == S_ISSUE) begin
            dram_addr = addr_r;
            dram_ba   = bank_r;
            case (cmd_r)
                CMD_ACT: {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = 4'b0011;
                CMD_RD:  {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = 4'b0101;
                CMD_WR:  {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = 4'b0100;
                CMD_PRE: {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = 4'b0010;
                CMD_REF: {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = 4'b0001;
                default: {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n} = 4'b1111;
            endcase
            rd_issue = (cmd_r == CMD_RD);
            wr_issue = (cmd_r == CMD_WR);
        end
    end

    assign busy = (state != S_IDLE);

endmodule
